sound_master_out: RTL and testbench

//   Output stage downstream of the sound mixer. Decimates the per-clock mixed sample_l/sample_r stream to a fixed output rate.

---
 rtl/sound_master_out.sv | 160 ++++++++++++++++
 tb/tb_sound_master_out.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_master_out.sv
// sound_master_out: output stage after the sound mixer.
//   Decimates the per-clock mixed stream to OUT_RATE with a phase accumulator. Applies a master
//   gain (arithmetic shift, 16 = silent) that ramps one step per output tick so volume changes
//   never zipper. Holds the output silent for SETTLE_TICKS ticks after reset to hide power-up pops.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   clock_rate[27:0]  clk frequency in Hz (registered every clk, may change at runtime)
//   in_l/in_r[15:0]   signed mixed samples, captured only on an output tick
//   vol_l/vol_r[4:0]  master volume (0 = silent, else shift by ~vol[4:1])
//   mute              forces both gain targets to silent
//   out_l/out_r[15:0] signed output samples, held between strobes
//   out_strobe        one-clk pulse when out_l/out_r update (two clks after the tick)
//   settled           high once the post-reset settle period has elapsed
module sound_master_out #(
  parameter int unsigned OUT_RATE     = 48000,
  parameter int unsigned SETTLE_TICKS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] clock_rate,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  input  logic [4:0]  vol_l,
  input  logic [4:0]  vol_r,
  input  logic        mute,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_strobe,
  output logic        settled
);

  localparam logic [4:0]  GainSilent = 5'd16;
  localparam logic [11:0] SettleLast = 12'(SETTLE_TICKS - 1);

  typedef enum logic [0:0] {StSettle, StRun} state_e;

  // Gain helpers
  function automatic logic [4:0] gain_target(input logic [4:0] vol, input logic m);
    if (m || (vol == 5'd0)) return GainSilent;
    return {1'b0, ~vol[4:1]};
  endfunction

  function automatic logic [4:0] gain_step(input logic [4:0] cur, input logic [4:0] tgt);
    if (cur > tgt) return cur - 5'd1;
    if (cur < tgt) return cur + 5'd1;
    return cur;
  endfunction

  function automatic logic [15:0] apply_gain(input logic [15:0] x, input logic [4:0] code);
    if (code[4]) return 16'd0;
    return 16'($signed(x) >>> code[3:0]);
  endfunction

  // Tick generator
  logic [27:0] rate_q;
  logic [31:0] acc_q, acc_d, acc_sum;
  logic        tick;

  always_comb begin
    acc_sum = acc_q + OUT_RATE;
    acc_d   = acc_q;
    tick    = 1'b0;
    // rate 0 freezes the accumulator entirely
    if (rate_q != 28'd0) begin
      if (acc_sum >= {4'd0, rate_q}) begin
        tick  = 1'b1;
        acc_d = acc_sum - {4'd0, rate_q};
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Settle / ramp FSM
  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        settled_q, settled_d;
  logic [4:0]  cur_l_q, cur_l_d, cur_r_q, cur_r_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    cur_l_d   = cur_l_q;
    cur_r_d   = cur_r_q;
    if (tick) begin
      case (state_q)
        StSettle: begin
          cur_l_d = GainSilent;
          cur_r_d = GainSilent;
          if (cnt_q == SettleLast) begin
            state_d   = StRun;
            settled_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        StRun: begin
          cur_l_d = gain_step(cur_l_q, gain_target(vol_l, mute));
          cur_r_d = gain_step(cur_r_q, gain_target(vol_r, mute));
        end
        default: state_d = StSettle;
      endcase
    end
  end

  // Pipeline: P0 captures sample + pre-step gain on the tick, P1 scales and registers
  logic        p0_valid_q;
  logic [15:0] x_l_q, x_r_q;
  logic [4:0]  g_l_q, g_r_q;
  logic [15:0] out_l_q, out_r_q;
  logic        strobe_q;

  always_ff @(posedge clk) begin
    rate_q <= clock_rate;
  end

  always_ff @(posedge clk) begin
    if (tick) begin
      x_l_q <= in_l;
      x_r_q <= in_r;
      g_l_q <= cur_l_q;
      g_r_q <= cur_r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      state_q    <= StSettle;
      cnt_q      <= '0;
      settled_q  <= 1'b0;
      cur_l_q    <= GainSilent;
      cur_r_q    <= GainSilent;
      p0_valid_q <= 1'b0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      strobe_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      settled_q  <= settled_d;
      cur_l_q    <= cur_l_d;
      cur_r_q    <= cur_r_d;
      p0_valid_q <= tick;
      strobe_q   <= p0_valid_q;
      if (p0_valid_q) begin
        out_l_q <= apply_gain(x_l_q, g_l_q);
        out_r_q <= apply_gain(x_r_q, g_r_q);
      end
    end
  end

  assign out_l      = out_l_q;
  assign out_r      = out_r_q;
  assign out_strobe = strobe_q;
  assign settled    = settled_q;

endmodule

// File: tb/tb_sound_master_out.sv
// Bench for sound_master_out: reference model (accumulator arithmetic, per-tick gain walk and a
// due-time queue of pending outputs) checked every clock, plus directed sequences and a table of
// steady-state volume settings.
module tb_sound_master_out;

  localparam int unsigned OutRate = 48000;
  localparam int unsigned Settle  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] clock_rate;
  logic [15:0] in_l, in_r;
  logic [4:0]  vol_l, vol_r;
  logic        mute;
  logic [15:0] out_l, out_r;
  logic        out_strobe, settled;

  int checks = 0;
  int errors = 0;

  sound_master_out #(
    .OUT_RATE    (OutRate),
    .SETTLE_TICKS(Settle)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clock_rate(clock_rate),
    .in_l      (in_l),
    .in_r      (in_r),
    .vol_l     (vol_l),
    .vol_r     (vol_r),
    .mute      (mute),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_strobe(out_strobe),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint      due;
    logic [15:0] l;
    logic [15:0] r;
  } pend_t;

  pend_t       pq[$];
  longint      edge_n  = 0;
  longint      m_acc   = 0;
  longint      m_rate  = 0;
  bit          m_run   = 0;
  int          m_seen  = 0;
  int          m_cur_l = 16;
  int          m_cur_r = 16;
  logic [15:0] m_out_l = 16'd0;
  logic [15:0] m_out_r = 16'd0;
  bit          m_strobe  = 0;
  bit          m_settled = 0;

  function automatic logic [15:0] scale(input logic [15:0] x, input int shift);
    int xi;
    xi = int'($signed(x));
    if (shift >= 16) return 16'd0;
    return 16'(xi >>> shift);
  endfunction

  function automatic int target(input logic [4:0] v, input logic m);
    if (m || v == 5'd0) return 16;
    return 15 - int'(v[4:1]);
  endfunction

  function automatic int toward(input int cur, input int tgt);
    if (cur > tgt) return cur - 1;
    if (cur < tgt) return cur + 1;
    return cur;
  endfunction

  task automatic model_step();
    bit tick;
    edge_n++;
    if (rst) begin
      pq.delete();
      m_acc = 0; m_run = 0; m_seen = 0; m_cur_l = 16; m_cur_r = 16;
      m_out_l = 0; m_out_r = 0; m_strobe = 0; m_settled = 0;
      m_rate = longint'(clock_rate);
      return;
    end
    m_strobe = 0;
    if (pq.size() > 0 && pq[0].due == edge_n) begin
      m_out_l  = pq[0].l;
      m_out_r  = pq[0].r;
      m_strobe = 1;
      pq.delete(0);
    end
    tick = 0;
    if (m_rate != 0) begin
      if (m_acc + OutRate >= m_rate) begin
        tick  = 1;
        m_acc = m_acc + OutRate - m_rate;
      end else begin
        m_acc = m_acc + OutRate;
      end
    end
    m_rate = longint'(clock_rate);
    if (tick) begin
      pq.push_back('{edge_n + 1, scale(in_l, m_cur_l), scale(in_r, m_cur_r)});
      if (!m_run) begin
        m_seen++;
        if (m_seen == Settle) begin
          m_run = 1;
          m_settled = 1;
        end
      end else begin
        m_cur_l = toward(m_cur_l, target(vol_l, mute));
        m_cur_r = toward(m_cur_r, target(vol_r, mute));
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_out_l", 32'(out_l), 32'(m_out_l));
      check("model_out_r", 32'(out_r), 32'(m_out_r));
      check("model_strobe", 32'(out_strobe), 32'(m_strobe));
      check("model_settled", 32'(settled), 32'(m_settled));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_strobe(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_strobe) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no strobe within %0d clk, expected one", name, budget);
  endtask

  typedef struct {
    logic [4:0]  vl, vr;
    logic        m;
    logic [15:0] il, ir;
    logic [15:0] el, er;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt, gap, last;
    logic [15:0] hold_l, hold_r;
    logic [27:0] rates[3];

    vecs[0] = '{5'h1F, 5'h1F, 1'b0, 16'h4000, 16'h8000, 16'h4000, 16'h8000};
    vecs[1] = '{5'h11, 5'h1F, 1'b0, 16'h8000, 16'h8000, 16'hFF00, 16'h8000};
    vecs[2] = '{5'h01, 5'h03, 1'b0, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
    vecs[3] = '{5'h1F, 5'h1F, 1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
    vecs[4] = '{5'h00, 5'h1F, 1'b0, 16'h7FFF, 16'h1234, 16'h0000, 16'h1234};
    vecs[5] = '{5'h1F, 5'h1D, 1'b0, 16'hEDCC, 16'h1234, 16'hEDCC, 16'h091A};
    rates   = '{28'd100000, 28'd240000, 28'd480000};

    rst = 1'b1; clock_rate = 28'd480000; in_l = 16'h4000; in_r = 16'h4000;
    vol_l = 5'h1F; vol_r = 5'h1F; mute = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_l", 32'(out_l), 32'h0);
    check("reset_strobe", 32'(out_strobe), 32'h0);
    check("reset_settled", 32'(settled), 32'h0);
    rst = 1'b0;

    // Settle period then ramp-up from silent to full scale
    for (int i = 0; i < Settle; i++) begin
      wait_strobe("settle_strobe", 20);
      check("settle_zero", 32'(out_l), 32'h0);
    end
    check("settled_high", 32'(settled), 32'h1);
    for (int k = 16; k >= 0; k--) begin
      wait_strobe("ramp_up_strobe", 20);
      check("ramp_up", 32'(out_l), 32'(scale(16'h4000, k)));
    end

    // Mute ramp-down
    in_l = 16'h7FFF;
    wait_strobe("pre_mute", 20);
    wait_strobe("pre_mute", 20);
    mute = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      wait_strobe("mute_strobe", 20);
      check("mute_ramp", 32'(out_l), 32'(scale(16'h7FFF, k)));
    end
    mute = 1'b0;

    // Strobe cadence: 100 strobes in 1000 clk, spaced 10 apart
    wait_strobe("cadence_start", 20);
    cnt = 0; last = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (out_strobe) begin
        cnt++;
        gap = i - last;
        last = i;
        check("strobe_gap", 32'(gap), 32'd10);
      end
    end
    check("strobe_count", 32'(cnt), 32'd100);

    // Steady-state table
    foreach (vecs[i]) begin
      vol_l = vecs[i].vl; vol_r = vecs[i].vr; mute = vecs[i].m;
      in_l = vecs[i].il; in_r = vecs[i].ir;
      repeat (20) wait_strobe("table_strobe", 20);
      check($sformatf("table%0d_l", i), 32'(out_l), 32'(vecs[i].el));
      check($sformatf("table%0d_r", i), 32'(out_r), 32'(vecs[i].er));
    end

    // clock_rate = 0: outputs freeze, then resume
    vol_l = 5'h1F; vol_r = 5'h1F; mute = 1'b0;
    clock_rate = 28'd0;
    repeat (5) @(negedge clk);
    hold_l = out_l; hold_r = out_r;
    cnt = 0;
    for (int i = 0; i < 495; i++) begin
      @(negedge clk);
      if (out_strobe) cnt++;
    end
    check("rate0_strobes", 32'(cnt), 32'd0);
    check("rate0_hold_l", 32'(out_l), 32'(hold_l));
    check("rate0_hold_r", 32'(out_r), 32'(hold_r));
    clock_rate = 28'd480000;
    wait_strobe("rate_resume", 14);

    // Randomized traffic at several rates
    foreach (rates[r]) begin
      clock_rate = rates[r];
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk);
        in_l = 16'($urandom);
        in_r = 16'($urandom);
        if ($urandom_range(0, 39) == 0) begin
          vol_l = 5'($urandom);
          vol_r = 5'($urandom);
          mute  = ($urandom_range(0, 3) == 0);
        end
      end
    end
    vol_l = 5'h1F; vol_r = 5'h1F; mute = 1'b0; in_l = 16'h4000; in_r = 16'h4000;

    // Reset one clk after a tick cancels the pending strobe
    wait_strobe("pre_reset", 20);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_l", 32'(out_l), 32'h0);
    check("rst_out_r", 32'(out_r), 32'h0);
    check("rst_settled", 32'(settled), 32'h0);
    check("rst_strobe", 32'(out_strobe), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_strobe", 32'(out_strobe), 32'h0);
    end
    for (int i = 0; i < Settle; i++) begin
      wait_strobe("resettle_strobe", 20);
      check("resettle_zero", 32'(out_l), 32'h0);
    end
    check("resettled", 32'(settled), 32'h1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
